// File: rtl/dmem_store_responder.sv
// dmem_store_responder: data-memory responder with a store FIFO, a word RAM, one-cycle loads and a test mailbox
module dmem_store_responder #(
  parameter int          MEM_WORDS  = 64,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] MBOX_ADDR  = 32'd100,
  parameter logic [31:0] PASS_VALUE = 32'd7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic                       MemRead,
  input  logic [31:0]                ALUResult,
  input  logic [31:0]                WriteData,
  output logic [31:0]                ReadData,
  output logic                       ReadValid,
  output logic                       Stall,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Done,
  output logic                       Pass,
  output logic [31:0]                MboxData
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, RESP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     rd_data_q, rd_data_d, mbox_q, mbox_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic [AW-1:0]   fifo_idx_q [DEPTH];
  logic [31:0]     fifo_dat_q [DEPTH];
  logic [31:0]     ram_q [MEM_WORDS];
  logic [AW-1:0]   idx;
  logic            full, empty, resp, push, pop, ld_acc, mbox_hit;
  // request decode: a store only waits on a full FIFO or the response cycle; a load also waits for the FIFO to drain and for any concurrent store
  always_comb begin
    idx      = ALUResult[2 +: AW];
    full     = count_q == CW'(DEPTH);
    empty    = count_q == '0;
    resp     = state_q == RESP;
    push     = MemWrite & !full & !resp;
    pop      = !empty;
    ld_acc   = MemRead & !MemWrite & empty & !resp;
    mbox_hit = push & (ALUResult == MBOX_ADDR);
    Stall    = reset & ((MemWrite & full) | (MemRead & (MemWrite | !empty)) | (resp & (MemRead | MemWrite)));
  end
  // next-state: FIFO pointers/occupancy, load response FSM, mailbox capture
  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    state_d   = ld_acc ? RESP : IDLE;
    rd_data_d = ld_acc ? ram_q[idx] : rd_data_q;
    done_d    = done_q | mbox_hit;
    pass_d    = mbox_hit ? (WriteData == PASS_VALUE) : pass_q;
    mbox_d    = mbox_hit ? WriteData : mbox_q;
  end
  // control state; reset discards queued stores by clearing the pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mbox_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      mbox_q    <= mbox_d;
    end
  end
  // storage: FIFO slots are filled on accept, the head drains into RAM every non-empty cycle
  always_ff @(posedge clk) begin
    if (push && reset) begin
      fifo_idx_q[wr_ptr_q] <= idx;
      fifo_dat_q[wr_ptr_q] <= WriteData;
    end
    if (pop && reset) ram_q[fifo_idx_q[rd_ptr_q]] <= fifo_dat_q[rd_ptr_q];
  end
  assign ReadData  = rd_data_q;
  assign ReadValid = resp;
  assign Count     = count_q;
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign MboxData  = mbox_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));
  a_count_max:   assert property (@(posedge clk) disable iff (!reset) count_q <= CW'(DEPTH));
endmodule
